// File: rtl/usb_pkg.sv
// Shared USB transaction-layer encodings: token types, handshake codes,
// DATA PID types and the one-hot state encoding of the bulk endpoint FSM.
package usb_pkg;

  typedef enum logic [1:0] {
    TOK_OUT   = 2'b00,
    TOK_IN    = 2'b10,
    TOK_SETUP = 2'b11
  } tok_e;

  typedef enum logic [1:0] {
    HSK_ACK   = 2'b00,
    HSK_NAK   = 2'b10,
    HSK_STALL = 2'b11,
    HSK_NYET  = 2'b01
  } hsk_e;

  typedef enum logic [1:0] {
    PID_DATA0 = 2'b00,
    PID_DATA1 = 2'b10
  } data_pid_e;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_OUT_DATA = 6'b000010,
    ST_IN_START = 6'b000100,
    ST_IN_DATA  = 6'b001000,
    ST_IN_WAIT  = 6'b010000,
    ST_SEND_HSK = 6'b100000
  } state_e;

endpackage

// File: rtl/usb_bulk_ep_trn.sv
// Bulk IN/OUT endpoint transaction sequencer.
// Consumes token/data/handshake strobes from the USB packet layer, owns the
// DATA0/DATA1 toggles, forwards OUT payloads to m_axis (one-byte holding
// register so tlast lands on the final byte) and streams IN payloads from a
// store-and-forward source on s_axis, signalling commit or rewind.
// Ports:
//   trn_*          token from the packet layer
//   rx_trn_*       received data packet / host handshake
//   tx_trn_*       handshake and IN data requests to the packet layer
//   m_axis_*       OUT payload sink (no backpressure, gated by out_space)
//   s_axis_*       IN payload source; in_zlp/in_commit/in_rewind control it
//   ep_halt        reply STALL; clr_toggle resets both toggles to DATA0
module usb_bulk_ep_trn
  import usb_pkg::*;
#(
  parameter logic [3:0]  ENDPOINT = 4'd1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] trn_type,
  input  logic [3:0] trn_endpoint,
  input  logic       trn_start,
  input  logic [1:0] rx_trn_data_type,
  input  logic       rx_trn_valid,
  input  logic [7:0] rx_trn_data,
  input  logic       rx_trn_end,
  input  logic       crc_error,
  input  logic       rx_trn_hsk_received,
  input  logic [1:0] rx_trn_hsk_type,
  output logic       tx_trn_send_hsk,
  output logic [1:0] tx_trn_hsk_type,
  input  logic       tx_trn_hsk_sended,
  output logic       tx_trn_data_start,
  output logic [1:0] tx_trn_data_type,
  output logic [7:0] tx_trn_data,
  output logic       tx_trn_data_valid,
  output logic       tx_trn_data_last,
  input  logic       tx_trn_data_ready,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic [7:0] m_axis_tdata,
  input  logic       out_space,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  output logic       s_axis_tready,
  input  logic       in_zlp,
  output logic       in_commit,
  output logic       in_rewind,
  input  logic       ep_halt,
  input  logic       clr_toggle
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic          out_toggle;
  logic          in_toggle;
  logic          nak;
  logic          stall;
  logic          fwd;
  logic          first;
  logic          zlp;
  logic [7:0]    hold_data;
  logic          hold_valid;
  logic [TW-1:0] timer;

  logic tok_hit;
  logic rx_match;
  logic fwd_now;
  logic timer_done;
  logic unused_pid_lsb;

  assign tok_hit        = trn_start && (trn_endpoint == ENDPOINT);
  assign rx_match       = rx_trn_data_type[1] == out_toggle;
  // Forward decision is taken on the first byte and held for the packet.
  assign fwd_now        = first ? (!nak && rx_match) : fwd;
  assign timer_done     = timer == TW'(TIMEOUT);
  assign unused_pid_lsb = rx_trn_data_type[0];

  // IN payload passes straight through from the source while streaming.
  always_comb begin
    tx_trn_data       = 8'h00;
    tx_trn_data_valid = 1'b0;
    tx_trn_data_last  = 1'b0;
    s_axis_tready     = 1'b0;
    if (state == ST_IN_DATA) begin
      if (zlp) begin
        tx_trn_data_last = 1'b1;
      end else begin
        tx_trn_data       = s_axis_tdata;
        tx_trn_data_valid = s_axis_tvalid;
        tx_trn_data_last  = s_axis_tlast;
        s_axis_tready     = tx_trn_data_ready;
      end
    end
  end

  // Transaction FSM with registered outputs and toggle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      out_toggle        <= 1'b0;
      in_toggle         <= 1'b0;
      nak               <= 1'b0;
      stall             <= 1'b0;
      fwd               <= 1'b0;
      first             <= 1'b0;
      zlp               <= 1'b0;
      hold_data         <= 8'h00;
      hold_valid        <= 1'b0;
      timer             <= '0;
      tx_trn_send_hsk   <= 1'b0;
      tx_trn_hsk_type   <= 2'b00;
      tx_trn_data_start <= 1'b0;
      tx_trn_data_type  <= 2'b00;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      m_axis_tdata      <= 8'h00;
      in_commit         <= 1'b0;
      in_rewind         <= 1'b0;
    end else begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      tx_trn_data_start <= 1'b0;
      in_commit         <= 1'b0;
      in_rewind         <= 1'b0;
      if (!timer_done) timer <= timer + 1'b1;

      case (state)
        ST_IDLE: begin
          if (tok_hit && trn_type == TOK_OUT) begin
            state      <= ST_OUT_DATA;
            nak        <= ep_halt || !out_space;
            stall      <= ep_halt;
            first      <= 1'b1;
            hold_valid <= 1'b0;
            timer      <= '0;
          end else if (tok_hit && trn_type == TOK_IN) begin
            if (ep_halt) begin
              state           <= ST_SEND_HSK;
              tx_trn_send_hsk <= 1'b1;
              tx_trn_hsk_type <= HSK_STALL;
            end else if (!s_axis_tvalid && !in_zlp) begin
              state           <= ST_SEND_HSK;
              tx_trn_send_hsk <= 1'b1;
              tx_trn_hsk_type <= HSK_NAK;
            end else begin
              state             <= ST_IN_START;
              tx_trn_data_start <= 1'b1;
              tx_trn_data_type  <= {in_toggle, 1'b0};
            end
          end
        end

        ST_OUT_DATA: begin
          if (rx_trn_end) begin
            // Flush the held byte as the last beat; CRC failure marks it bad.
            if (hold_valid) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= crc_error;
              m_axis_tdata  <= hold_data;
              hold_valid    <= 1'b0;
            end
            if (crc_error) begin
              state <= ST_IDLE;
            end else begin
              state           <= ST_SEND_HSK;
              tx_trn_send_hsk <= 1'b1;
              if (stall) begin
                tx_trn_hsk_type <= HSK_STALL;
              end else if (nak) begin
                tx_trn_hsk_type <= HSK_NAK;
              end else begin
                // A duplicate (toggle mismatch) is ACKed without flipping.
                tx_trn_hsk_type <= HSK_ACK;
                if (rx_match) out_toggle <= ~out_toggle;
              end
            end
          end else if (timer_done) begin
            state <= ST_IDLE;
          end else if (rx_trn_valid) begin
            first <= 1'b0;
            fwd   <= fwd_now;
            if (fwd_now) begin
              if (hold_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= hold_data;
              end
              hold_data  <= rx_trn_data;
              hold_valid <= 1'b1;
            end
          end
        end

        ST_IN_START: begin
          state <= ST_IN_DATA;
          zlp   <= !s_axis_tvalid;
        end

        ST_IN_DATA: begin
          if (zlp || (s_axis_tvalid && tx_trn_data_ready && s_axis_tlast)) begin
            state <= ST_IN_WAIT;
            timer <= '0;
          end
        end

        ST_IN_WAIT: begin
          if (rx_trn_hsk_received) begin
            state <= ST_IDLE;
            if (rx_trn_hsk_type == HSK_ACK) begin
              in_commit <= 1'b1;
              in_toggle <= ~in_toggle;
            end else begin
              in_rewind <= 1'b1;
            end
          end else if (timer_done) begin
            state     <= ST_IDLE;
            in_rewind <= 1'b1;
          end
        end

        ST_SEND_HSK: begin
          if (tx_trn_hsk_sended) begin
            tx_trn_send_hsk <= 1'b0;
            state           <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Toggle clear wins over any flip in the same cycle.
      if (clr_toggle) begin
        out_toggle <= 1'b0;
        in_toggle  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_bulk_ep_trn.sv
// Bench for usb_bulk_ep_trn: transaction-level model with expectation queues,
// a per-cycle monitor, a host-side handshake responder and a packet source.
module tb_usb_bulk_ep_trn;
  import usb_pkg::*;

  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] trn_type;
  logic [3:0] trn_endpoint;
  logic       trn_start;
  logic [1:0] rx_trn_data_type;
  logic       rx_trn_valid;
  logic [7:0] rx_trn_data;
  logic       rx_trn_end;
  logic       crc_error;
  logic       rx_trn_hsk_received;
  logic [1:0] rx_trn_hsk_type;
  logic       tx_trn_send_hsk;
  logic [1:0] tx_trn_hsk_type;
  logic       tx_trn_hsk_sended;
  logic       tx_trn_data_start;
  logic [1:0] tx_trn_data_type;
  logic [7:0] tx_trn_data;
  logic       tx_trn_data_valid;
  logic       tx_trn_data_last;
  logic       tx_trn_data_ready;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic [7:0] m_axis_tdata;
  logic       out_space;
  logic       s_axis_tvalid;
  logic       s_axis_tlast;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tready;
  logic       in_zlp;
  logic       in_commit;
  logic       in_rewind;
  logic       ep_halt;
  logic       clr_toggle;

  always #5 clk = ~clk;

  usb_bulk_ep_trn #(.ENDPOINT(4'd1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .trn_type(trn_type), .trn_endpoint(trn_endpoint), .trn_start(trn_start),
    .rx_trn_data_type(rx_trn_data_type), .rx_trn_valid(rx_trn_valid),
    .rx_trn_data(rx_trn_data), .rx_trn_end(rx_trn_end), .crc_error(crc_error),
    .rx_trn_hsk_received(rx_trn_hsk_received), .rx_trn_hsk_type(rx_trn_hsk_type),
    .tx_trn_send_hsk(tx_trn_send_hsk), .tx_trn_hsk_type(tx_trn_hsk_type),
    .tx_trn_hsk_sended(tx_trn_hsk_sended), .tx_trn_data_start(tx_trn_data_start),
    .tx_trn_data_type(tx_trn_data_type), .tx_trn_data(tx_trn_data),
    .tx_trn_data_valid(tx_trn_data_valid), .tx_trn_data_last(tx_trn_data_last),
    .tx_trn_data_ready(tx_trn_data_ready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tdata(m_axis_tdata),
    .out_space(out_space),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .in_zlp(in_zlp), .in_commit(in_commit), .in_rewind(in_rewind),
    .ep_halt(ep_halt), .clr_toggle(clr_toggle)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state and expectation queues.
  bit         m_out_tog = 1'b0;
  bit         m_in_tog  = 1'b0;
  bit         m_src_valid = 1'b0;
  logic [7:0] m_pkt[$];
  logic [9:0] q_m[$];      // {tlast, tuser, data}
  logic [9:0] q_tx[$];     // {zlp, last, data}
  logic [1:0] q_hsk[$];
  logic [1:0] q_start[$];
  logic [1:0] q_ev[$];     // 1 commit, 2 rewind
  logic [7:0] pkt[$];

  // Packet source with commit/rewind semantics.
  logic [7:0] src_mem [0:15];
  int         src_len = 0;
  int         src_ptr = 0;
  assign s_axis_tvalid = src_ptr < src_len;
  assign s_axis_tdata  = src_mem[src_ptr[3:0]];
  assign s_axis_tlast  = (src_ptr == src_len - 1);

  initial begin
    logic adv, com, rew;
    forever begin
      @(negedge clk);
      adv = s_axis_tvalid && s_axis_tready;
      com = in_commit;
      rew = in_rewind;
      @(posedge clk);
      #1;
      if (com) begin
        src_len = 0;
        src_ptr = 0;
      end else if (rew) begin
        src_ptr = 0;
      end else if (adv) begin
        src_ptr++;
      end
    end
  end

  // Packet layer accepts a handshake one cycle after it is requested.
  initial begin
    tx_trn_hsk_sended = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_trn_hsk_sended = tx_trn_send_hsk && !tx_trn_hsk_sended;
    end
  end

  // Per-cycle monitor against the expectation queues.
  logic       prev_hsk = 1'b0;
  logic [1:0] last_hsk = 2'b01;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_axis_tvalid)
          check("m_axis_beat", {22'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                q_m.size() > 0 ? {22'd0, q_m.pop_front()} : 32'hDEADBEEF);
        if ((tx_trn_data_valid && tx_trn_data_ready) || (tx_trn_data_last && !tx_trn_data_valid))
          check("in_beat", {22'd0, !tx_trn_data_valid, tx_trn_data_last, tx_trn_data},
                q_tx.size() > 0 ? {22'd0, q_tx.pop_front()} : 32'hDEADBEEF);
        if (tx_trn_data_start)
          check("in_data_pid", {30'd0, tx_trn_data_type},
                q_start.size() > 0 ? {30'd0, q_start.pop_front()} : 32'hDEADBEEF);
        if (tx_trn_send_hsk && !prev_hsk) begin
          last_hsk = tx_trn_hsk_type;
          check("hsk_type", {30'd0, tx_trn_hsk_type},
                q_hsk.size() > 0 ? {30'd0, q_hsk.pop_front()} : 32'hDEADBEEF);
        end
        prev_hsk = tx_trn_send_hsk;
        if (in_commit)
          check("in_commit", 32'd1, q_ev.size() > 0 ? {30'd0, q_ev.pop_front()} : 32'hDEADBEEF);
        if (in_rewind)
          check("in_rewind", 32'd2, q_ev.size() > 0 ? {30'd0, q_ev.pop_front()} : 32'hDEADBEEF);
      end else begin
        prev_hsk = 1'b0;
      end
    end
  end

  function automatic logic [29:0] all_outs();
    return {tx_trn_send_hsk, tx_trn_hsk_type, tx_trn_data_start, tx_trn_data_type,
            tx_trn_data, tx_trn_data_valid, tx_trn_data_last, m_axis_tvalid,
            m_axis_tlast, m_axis_tuser, m_axis_tdata, s_axis_tready, in_commit, in_rewind};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pkt_set(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pkt.delete();
    if (n > 0) pkt.push_back(a);
    if (n > 1) pkt.push_back(b);
    if (n > 2) pkt.push_back(c);
  endtask

  task automatic token(input logic [1:0] ty, input logic [3:0] ep);
    trn_type = ty;
    trn_endpoint = ep;
    trn_start = 1'b1;
    tick();
    trn_start = 1'b0;
    tick();
  endtask

  task automatic send_pkt(input logic [1:0] pid, input bit crc);
    rx_trn_data_type = pid;
    foreach (pkt[i]) begin
      rx_trn_valid = 1'b1;
      rx_trn_data  = pkt[i];
      tick();
    end
    rx_trn_valid = 1'b0;
    rx_trn_end   = 1'b1;
    crc_error    = crc;
    tick();
    rx_trn_end = 1'b0;
    crc_error  = 1'b0;
    tick(8);
  endtask

  // OUT transaction: model expectation first, then drive the bus.
  task automatic out_txn(input logic [1:0] pid, input bit crc, input bit space, input bit halt);
    bit nak_m, match;
    nak_m = halt || !space;
    match = pid[1] == m_out_tog;
    if (!nak_m && match)
      foreach (pkt[i])
        q_m.push_back({i == pkt.size() - 1, (i == pkt.size() - 1) && crc, pkt[i]});
    if (!crc) begin
      q_hsk.push_back(halt ? HSK_STALL : (nak_m ? HSK_NAK : HSK_ACK));
      if (!nak_m && match) m_out_tog = !m_out_tog;
    end
    out_space = space;
    ep_halt   = halt;
    token(TOK_OUT, 4'd1);
    send_pkt(pid, crc);
    ep_halt   = 1'b0;
    out_space = 1'b1;
  endtask

  task automatic load_src();
    foreach (pkt[i]) src_mem[i] = pkt[i];
    src_len = pkt.size();
    src_ptr = 0;
    m_pkt = pkt;
    m_src_valid = 1'b1;
  endtask

  // IN transaction; host: 0 ACK, 1 NAK handshake, 2 silent.
  task automatic in_txn(input bit halt, input int host);
    bool_data: begin end
    if (halt) begin
      q_hsk.push_back(HSK_STALL);
    end else if (!m_src_valid && !in_zlp) begin
      q_hsk.push_back(HSK_NAK);
    end else begin
      q_start.push_back({m_in_tog, 1'b0});
      if (m_src_valid)
        foreach (m_pkt[i]) q_tx.push_back({1'b0, i == m_pkt.size() - 1, m_pkt[i]});
      else
        q_tx.push_back({2'b11, 8'h00});
      if (host == 0) begin
        q_ev.push_back(2'd1);
        m_in_tog = !m_in_tog;
        m_src_valid = 1'b0;
      end else begin
        q_ev.push_back(2'd2);
      end
    end
    ep_halt = halt;
    token(TOK_IN, 4'd1);
    ep_halt = 1'b0;
    tick(6);
    if (!halt && (m_src_valid || in_zlp || host == 0)) begin
      if (host == 2) begin
        tick(TO + 4);
      end else if (host == 0 || host == 1) begin
        rx_trn_hsk_type = (host == 0) ? HSK_ACK : HSK_NAK;
        rx_trn_hsk_received = 1'b1;
        tick();
        rx_trn_hsk_received = 1'b0;
      end
    end
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    trn_type = 2'b00; trn_endpoint = 4'd0; trn_start = 1'b0;
    rx_trn_data_type = 2'b00; rx_trn_valid = 1'b0; rx_trn_data = 8'h00;
    rx_trn_end = 1'b0; crc_error = 1'b0;
    rx_trn_hsk_received = 1'b0; rx_trn_hsk_type = 2'b00;
    tx_trn_data_ready = 1'b1; out_space = 1'b1; in_zlp = 1'b0;
    ep_halt = 1'b0; clr_toggle = 1'b0;
    #2;
    check("reset_outputs", {2'd0, all_outs()}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // OUT DATA0 11 22 33: forwarded, ACK, out toggle -> 1.
    pkt_set(3, 8'h11, 8'h22, 8'h33);
    out_txn(PID_DATA0, 1'b0, 1'b1, 1'b0);
    check("out_ack_literal", {30'd0, last_hsk}, 32'd0);
    check("model_out_tog_1", {31'd0, m_out_tog}, 32'd1);
    // Duplicate DATA0: ACK, nothing forwarded.
    out_txn(PID_DATA0, 1'b0, 1'b1, 1'b0);
    check("dup_ack_literal", {30'd0, last_hsk}, 32'd0);
    // DATA1 with CRC error: bad last beat, no handshake.
    pkt_set(2, 8'h44, 8'h55, 8'h00);
    out_txn(PID_DATA1, 1'b1, 1'b1, 1'b0);
    // Good DATA1 still accepted: toggle survived the CRC error.
    pkt_set(1, 8'h66, 8'h00, 8'h00);
    out_txn(PID_DATA1, 1'b0, 1'b1, 1'b0);
    check("model_out_tog_0", {31'd0, m_out_tog}, 32'd0);
    // No space: NAK; halted: STALL.
    out_txn(PID_DATA0, 1'b0, 1'b0, 1'b0);
    check("out_nak_literal", {30'd0, last_hsk}, 32'd2);
    out_txn(PID_DATA0, 1'b0, 1'b1, 1'b1);
    check("out_stall_literal", {30'd0, last_hsk}, 32'd3);
    // Other endpoint and SETUP are ignored.
    pkt_set(1, 8'h77, 8'h00, 8'h00);
    token(TOK_OUT, 4'd2);
    send_pkt(PID_DATA0, 1'b0);
    token(TOK_SETUP, 4'd1);
    send_pkt(PID_DATA0, 1'b0);

    // IN AA BB: host silent -> rewind; resend DATA0; ACK -> commit.
    pkt_set(2, 8'hAA, 8'hBB, 8'h00);
    load_src();
    in_txn(1'b0, 2);
    check("src_rewound", src_ptr, 32'd0);
    in_txn(1'b0, 0);
    check("model_in_tog_1", {31'd0, m_in_tog}, 32'd1);
    check("src_freed", src_len, 32'd0);
    // Empty source: NAK; halted: STALL.
    in_txn(1'b0, 0);
    check("in_nak_literal", {30'd0, last_hsk}, 32'd2);
    in_txn(1'b1, 0);
    check("in_stall_literal", {30'd0, last_hsk}, 32'd3);
    // Clear toggles, then zero-length packet goes out as DATA0.
    clr_toggle = 1'b1;
    tick();
    clr_toggle = 1'b0;
    m_out_tog = 1'b0;
    m_in_tog  = 1'b0;
    in_zlp = 1'b1;
    in_txn(1'b0, 0);
    in_zlp = 1'b0;
    // Move out toggle to 1 so reset has something to clear.
    pkt_set(1, 8'h88, 8'h00, 8'h00);
    out_txn(PID_DATA0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of IN_DATA with the packet layer stalled.
    pkt_set(2, 8'hDD, 8'hEE, 8'h00);
    load_src();
    tx_trn_data_ready = 1'b0;
    q_start.push_back({m_in_tog, 1'b0});
    token(TOK_IN, 4'd1);
    tick(2);
    check("in_data_stalled", {31'd0, tx_trn_data_valid & ~s_axis_tready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midpkt_reset_outputs", {2'd0, all_outs()}, 32'd0);
    src_len = 0;
    src_ptr = 0;
    m_src_valid = 1'b0;
    m_out_tog = 1'b0;
    m_in_tog  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tx_trn_data_ready = 1'b1;
    tick(2);
    // Toggles back at DATA0 after reset.
    pkt_set(1, 8'h77, 8'h00, 8'h00);
    out_txn(PID_DATA0, 1'b0, 1'b1, 1'b0);
    pkt_set(1, 8'h99, 8'h00, 8'h00);
    load_src();
    in_txn(1'b0, 0);

    tick(4);
    check("q_m_drained", q_m.size(), 32'd0);
    check("q_tx_drained", q_tx.size(), 32'd0);
    check("q_hsk_drained", q_hsk.size(), 32'd0);
    check("q_start_drained", q_start.size(), 32'd0);
    check("q_ev_drained", q_ev.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_bulk_ep_trn.md
Name: usb_bulk_ep_trn

Overview:
Transaction sequencer for one bulk IN/OUT endpoint pair. It sits directly downstream of the USB packet layer and consumes its token, data and handshake strobes. It also drives the packet layer's handshake and data transmit requests. It owns the DATA0/DATA1 toggle state and adapts OUT payloads and IN payloads to AXI-stream interfaces. The IN source must be a store-and-forward packet buffer that supports commit and rewind.

Parameters:
ENDPOINT, 4'd1, endpoint number served; tokens for other endpoints are ignored.
TIMEOUT, 1024, cycles to wait for the OUT data packet or the IN host handshake before abandoning the transaction.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
trn_type  in  2  token type: 00 OUT, 10 IN, 11 SETUP
trn_endpoint  in  4  token endpoint
trn_start  in  1  one-cycle pulse: valid token addressed to this device
rx_trn_data_type  in  2  received DATA PID: 00 DATA0, 10 DATA1
rx_trn_valid  in  1  received payload byte strobe
rx_trn_data  in  8  received payload byte
rx_trn_end  in  1  pulse: end of data packet
crc_error  in  1  pulse, coincident with rx_trn_end on a CRC16 failure
rx_trn_hsk_received  in  1  pulse: host handshake received
rx_trn_hsk_type  in  2  00 ACK, 10 NAK, 11 STALL, 01 NYET
tx_trn_send_hsk  out  1  handshake request, level
tx_trn_hsk_type  out  2  handshake to send
tx_trn_hsk_sended  in  1  handshake accepted by the packet layer
tx_trn_data_start  out  1  one-cycle pulse: start an IN data packet
tx_trn_data_type  out  2  DATA PID type for the IN packet
tx_trn_data  out  8  IN payload byte
tx_trn_data_valid  out  1  IN payload byte valid
tx_trn_data_last  out  1  last IN payload byte
tx_trn_data_ready  in  1  packet layer accepts the byte
m_axis_tvalid  out  1  OUT payload stream valid
m_axis_tlast  out  1  OUT payload stream last
m_axis_tuser  out  1  on the last beat: 1 = packet bad, discard
m_axis_tdata  out  8  OUT payload stream data
out_space  in  1  sink can accept one full max-size packet
s_axis_tvalid  in  1  IN payload stream valid
s_axis_tlast  in  1  IN payload stream last
s_axis_tdata  in  8  IN payload stream data
s_axis_tready  out  1  IN payload stream ready
in_zlp  in  1  source has a zero-length packet pending
in_commit  out  1  pulse: host ACKed, source frees the packet
in_rewind  out  1  pulse: transmission failed, source rewinds to the packet start
ep_halt  in  1  endpoint halted: reply STALL
clr_toggle  in  1  pulse: both toggles reset to DATA0

Behaviour:
- Reset: FSM in IDLE; out_toggle = 0 and in_toggle = 0; all outputs 0; timer 0.
- Token qualifier: trn_start && trn_endpoint == ENDPOINT. SETUP tokens are ignored and the FSM stays in IDLE. Tokens arriving in any state other than IDLE are ignored.
- IDLE, qualified OUT token → OUT_DATA. Latch:
  - nak = ep_halt || !out_space
  - stall = ep_halt
  - Timer cleared.
- OUT_DATA:
  - On the first rx_trn_valid, latch fwd = !nak && (rx_trn_data_type[1] == out_toggle).
  - Bytes are forwarded only when fwd is set. A one-byte holding register is used: each new byte pushes the held byte out, with tlast = 0.
  - On rx_trn_end, the held byte is emitted with tlast = 1 and tuser = crc_error. A zero-length packet emits nothing.
  - On rx_trn_end:
    - crc_error → IDLE, no handshake.
    - otherwise → SEND_HSK with STALL if stall, NAK if nak, ACK otherwise.
    - ACK with a toggle match flips out_toggle.
    - ACK with a toggle mismatch (duplicate packet) leaves out_toggle unchanged and discards the data.
  - Timer reaches TIMEOUT → IDLE, no handshake.
  - m_axis has no backpressure; the sink guarantees acceptance via out_space.
- IDLE, qualified IN token:
  - ep_halt → SEND_HSK with STALL.
  - !s_axis_tvalid && !in_zlp → SEND_HSK with NAK.
  - else → IN_START.
- IN_START: tx_trn_data_start = 1 for one cycle, tx_trn_data_type = {in_toggle, 0}. The zero-length flag is latched as !s_axis_tvalid. Next state IN_DATA.
- IN_DATA:
  - For a zero-length packet, tx_trn_data_valid = 0 and tx_trn_data_last = 1 until the next state.
  - Otherwise, tx_trn_data_* pass straight through from s_axis, and s_axis_tready = tx_trn_data_ready.
  - Leave for IN_WAIT after the accepted beat with tlast, or one cycle after start for a zero-length packet.
  - The source must not drop tvalid mid-packet; the packet layer would truncate.
- IN_WAIT, timer cleared on entry:
  - rx_trn_hsk_received with ACK → in_commit pulse, flip in_toggle, IDLE.
  - Any other handshake, or timer reaches TIMEOUT → in_rewind pulse, IDLE, in_toggle unchanged.
- SEND_HSK: tx_trn_send_hsk held until tx_trn_hsk_sended, then deasserted for one cycle → IDLE.
- clr_toggle: clears both toggles in any state. It takes priority over a simultaneous flip.
- Timer: saturating counter, 0..TIMEOUT.

Decomposition:
- Shared package usb_pkg:
  - Token types: OUT, IN, SETUP.
  - Handshake codes: ACK, NAK, STALL, NYET.
  - Data PID types: DATA0, DATA1.
  - One-hot FSM state encodings.
- No sub-module. The OUT one-byte holding register is inline.

Test Plan:
- OUT to EP1 with DATA0 and bytes 11, 22, 33, out_space = 1 → m_axis emits 11, 22, 33; tlast on 33; tuser = 0. ACK sent; out_toggle = 1.
- Repeat the same DATA0 packet → ACK sent; no m_axis beats; out_toggle stays 1.
- OUT with DATA1 and crc_error on rx_trn_end → last beat has tuser = 1; no handshake; out_toggle unchanged.
- IN with s_axis holding AA, BB (tlast) → data_start with DATA0; two bytes sent. Host ACK → in_commit pulse; in_toggle = 1.
- IN; host sends nothing for TIMEOUT cycles → in_rewind pulse; next IN resends with DATA0.
- IN with empty source → NAK. With ep_halt = 1 → STALL. in_zlp = 1 → zero-length DATA0 packet. Assert rst_n low mid-IN_DATA → all outputs 0; FSM back to IDLE.
